// File: rtl/nand_cpu_pkg.sv
// Shared core constants and types for the rename path.
// NUM_REG is normally provided by nand_cpu.svh; a 32-register default is used when it is absent.
`ifndef NUM_REG
`define NUM_REG 32
`endif

package nand_cpu_pkg;

   localparam int NUM_REG  = `NUM_REG;
   localparam int NUM_ARCH = 16;
   localparam int ARCH_W   = 4;
   localparam int PREG_W   = $clog2(NUM_REG);

   typedef logic [PREG_W-1:0]  preg_t;
   typedef logic [ARCH_W-1:0]  arch_t;
   typedef logic [NUM_REG-1:0] pmask_t;

   function automatic pmask_t preg_onehot(input preg_t p);
      return pmask_t'(1) << p;
   endfunction

endpackage

// File: rtl/rename_map_free_list.sv
// Physical register free list: free mask, population counter and lowest-free-index grant.
// Flush loads a caller-supplied mask; the count is then NUM_REG-NUM_ARCH by construction.
module free_list
   import nand_cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc_en,
   input  logic            free_en,
   input  preg_t           free_idx,
   input  logic            flush,
   input  pmask_t          flush_mask,
   output preg_t           alloc_preg,
   output logic            alloc_ready,
   output logic [PREG_W:0] free_count
);

   localparam pmask_t          ARCH_MASK = pmask_t'({NUM_ARCH{1'b1}});
   localparam pmask_t          RST_MASK  = ~ARCH_MASK;
   localparam logic [PREG_W:0] RST_COUNT = (PREG_W+1)'(NUM_REG - NUM_ARCH);

   pmask_t          free_mask_q, free_mask_d;
   logic [PREG_W:0] free_count_q, free_count_d;

   // Scan from the top so the last hit is the lowest set bit.
   always_comb begin
      alloc_preg = '0;
      for (int i = NUM_REG-1; i >= 0; i--) begin
         if (free_mask_q[i]) alloc_preg = preg_t'(i);
      end
   end

   assign alloc_ready = |free_mask_q;
   assign free_count  = free_count_q;

   always_comb begin
      free_mask_d  = free_mask_q;
      free_count_d = free_count_q;
      if (flush) begin
         free_mask_d  = flush_mask;
         free_count_d = RST_COUNT;
      end else begin
         if (free_en)  free_mask_d[free_idx]   = 1'b1;
         if (alloc_en) free_mask_d[alloc_preg] = 1'b0;
         case ({free_en, alloc_en})
            2'b10:   free_count_d = free_count_q + (PREG_W+1)'(1);
            2'b01:   free_count_d = free_count_q - (PREG_W+1)'(1);
            default: free_count_d = free_count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         free_mask_q  <= RST_MASK;
         free_count_q <= RST_COUNT;
      end else begin
         free_mask_q  <= free_mask_d;
         free_count_q <= free_count_d;
      end
   end

endmodule

// File: rtl/rename_map.sv
// Register rename unit: speculative and retired arch->phys maps plus free list.
// Define RENAME_FLUSH_EN to get the flush port and the free-mask rebuild from the retired map.
module rename_map
   import nand_cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [3:0]        alloc_arch,
   output logic              alloc_ready,
   output logic [PREG_W-1:0] alloc_preg,
   output logic [PREG_W-1:0] translation [NUM_ARCH],
   input  logic              commit_valid,
   input  logic [3:0]        commit_arch,
   input  logic [PREG_W-1:0] commit_preg,
`ifdef RENAME_FLUSH_EN
   input  logic              flush,
`endif
   output logic [PREG_W:0]   free_count
);

   preg_t  spec_map_q [NUM_ARCH];
   preg_t  spec_map_d [NUM_ARCH];
   preg_t  ret_map_q  [NUM_ARCH];
   preg_t  ret_map_d  [NUM_ARCH];
   preg_t  old_preg;
   logic   alloc_fire;
   logic   free_en;
   logic   flush_int;
   pmask_t flush_mask;

   assign old_preg   = ret_map_q[commit_arch];
   // Re-committing the mapping already held frees nothing.
   assign free_en    = commit_valid && (old_preg != commit_preg);
   assign alloc_fire = alloc_valid && alloc_ready && !flush_int;

`ifdef RENAME_FLUSH_EN
   assign flush_int = flush;

   // Free set after flush is everything not held by the post-commit retired map.
   always_comb begin
      pmask_t held;
      held = '0;
      for (int i = 0; i < NUM_ARCH; i++) held = held | preg_onehot(ret_map_d[i]);
      flush_mask = ~held;
   end
`else
   assign flush_int  = 1'b0;
   assign flush_mask = '0;
`endif

   always_comb begin
      ret_map_d = ret_map_q;
      if (commit_valid) ret_map_d[commit_arch] = commit_preg;
   end

   always_comb begin
      spec_map_d = spec_map_q;
      if (flush_int)       spec_map_d = ret_map_d;
      else if (alloc_fire) spec_map_d[alloc_arch] = alloc_preg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ARCH; i++) begin
            spec_map_q[i] <= preg_t'(i);
            ret_map_q[i]  <= preg_t'(i);
         end
      end else begin
         spec_map_q <= spec_map_d;
         ret_map_q  <= ret_map_d;
      end
   end

   assign translation = spec_map_q;

   free_list u_free_list (
      .clk         (clk),
      .rst         (rst),
      .alloc_en    (alloc_fire),
      .free_en     (free_en),
      .free_idx    (old_preg),
      .flush       (flush_int),
      .flush_mask  (flush_mask),
      .alloc_preg  (alloc_preg),
      .alloc_ready (alloc_ready),
      .free_count  (free_count)
   );

endmodule

// File: tb/tb_rename_map.sv
// Randomized bench for rename_map against a map/free-set model with an in-order commit queue.
// Flush scenarios are exercised when RENAME_FLUSH_EN is defined.
module tb_rename_map;
   import nand_cpu_pkg::*;

`ifdef RENAME_FLUSH_EN
   localparam bit FLUSH_ON = 1'b1;
   logic flush = 1'b0;
`else
   localparam bit FLUSH_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              alloc_valid = 1'b0;
   logic [3:0]        alloc_arch = '0;
   logic              alloc_ready;
   logic [PREG_W-1:0] alloc_preg;
   logic [PREG_W-1:0] translation [16];
   logic              commit_valid = 1'b0;
   logic [3:0]        commit_arch = '0;
   logic [PREG_W-1:0] commit_preg = '0;
   logic [PREG_W:0]   free_count;

   rename_map dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_valid  (alloc_valid),
      .alloc_arch   (alloc_arch),
      .alloc_ready  (alloc_ready),
      .alloc_preg   (alloc_preg),
      .translation  (translation),
      .commit_valid (commit_valid),
      .commit_arch  (commit_arch),
      .commit_preg  (commit_preg),
`ifdef RENAME_FLUSH_EN
      .flush        (flush),
`endif
      .free_count   (free_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   int m_spec [16];
   int m_ret  [16];
   bit m_free [NUM_REG];
   int rob_a [$];
   int rob_p [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_spec[i] = i;
         m_ret[i]  = i;
      end
      for (int p = 0; p < NUM_REG; p++) m_free[p] = (p >= 16);
      rob_a.delete();
      rob_p.delete();
   endtask

   function automatic int m_grant();
      for (int p = 0; p < NUM_REG; p++) if (m_free[p]) return p;
      return -1;
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int p = 0; p < NUM_REG; p++) c += int'(m_free[p]);
      return c;
   endfunction

   task automatic check_all(input string tag);
      int g = m_grant();
      chk({tag, ".rdy"}, 32'(alloc_ready), 32'(g >= 0));
      if (g >= 0) chk({tag, ".preg"}, 32'(alloc_preg), g);
      chk({tag, ".cnt"}, 32'(free_count), m_count());
      for (int i = 0; i < 16; i++) chk($sformatf("%s.tr%0d", tag, i), 32'(translation[i]), m_spec[i]);
   endtask

   // Called at a falling edge: apply inputs, advance the model, clock once, check.
   task automatic drive(input string tag, input bit av, input int aa, input bit cv,
                        input int ca, input int cp, input bit fl);
      bit f = fl & FLUSH_ON;
      int g, old;
      alloc_valid  = av;
      alloc_arch   = 4'(aa);
      commit_valid = cv;
      commit_arch  = 4'(ca);
      commit_preg  = PREG_W'(cp);
`ifdef RENAME_FLUSH_EN
      flush = f;
`endif
      g = m_grant();
      if (cv) begin
         old = m_ret[ca];
         m_ret[ca] = cp;
         if (old != cp) m_free[old] = 1'b1;
      end
      if (f) begin
         for (int p = 0; p < NUM_REG; p++) m_free[p] = 1'b1;
         for (int i = 0; i < 16; i++) begin
            m_spec[i] = m_ret[i];
            m_free[m_ret[i]] = 1'b0;
         end
         rob_a.delete();
         rob_p.delete();
      end else if (av && g >= 0) begin
         m_free[g] = 1'b0;
         m_spec[aa] = g;
         rob_a.push_back(aa);
         rob_p.push_back(g);
      end
      @(posedge clk);
      @(negedge clk);
      alloc_valid  = 1'b0;
      commit_valid = 1'b0;
`ifdef RENAME_FLUSH_EN
      flush = 1'b0;
`endif
      check_all(tag);
   endtask

   // Commits always retire the oldest outstanding rename.
   task automatic step(input string tag, input bit av, input int aa, input bit cv, input bit fl);
      int ca = 0, cp = 0;
      bit c = 1'b0;
      if (cv && rob_a.size() > 0) begin
         ca = rob_a.pop_front();
         cp = rob_p.pop_front();
         c  = 1'b1;
      end
      drive(tag, av, aa, c, ca, cp, fl);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(negedge clk);
      m_reset();
      rst = 1'b0;
      check_all("rst");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_all("init");
      chk("init.preg16", 32'(alloc_preg), 16);
      chk("init.cnt16", 32'(free_count), 16);
      chk("init.rdy1", 32'(alloc_ready), 1);

      step("a0", 1'b1, 0, 1'b0, 1'b0);
      chk("a0.t0", 32'(translation[0]), 16);
      chk("a0.preg", 32'(alloc_preg), 17);
      chk("a0.cnt", 32'(free_count), 15);

      step("c0", 1'b0, 0, 1'b1, 1'b0);
      chk("c0.preg", 32'(alloc_preg), 0);
      chk("c0.cnt", 32'(free_count), 16);

      step("a1", 1'b1, 1, 1'b0, 1'b0);
      chk("ac.pre", 32'(alloc_preg), 17);
      step("ac", 1'b1, 2, 1'b1, 1'b0);
      chk("ac.t2", 32'(translation[2]), 17);
      chk("ac.cnt", 32'(free_count), 15);
      chk("ac.next", 32'(alloc_preg), 1);

      drive("csame", 1'b0, 0, 1'b1, 5, 5, 1'b0);
      chk("csame.cnt", 32'(free_count), 15);

      // Asynchronous reset while a request is pending.
      #2;
      alloc_valid = 1'b1;
      alloc_arch  = 4'd3;
      rst = 1'b1;
      #1;
      chk("arst.cnt", 32'(free_count), 16);
      chk("arst.preg", 32'(alloc_preg), 16);
      chk("arst.t2", 32'(translation[2]), 2);
      @(posedge clk);
      @(negedge clk);
      m_reset();
      check_all("arst.hold");
      alloc_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_all("arst.rel");

      for (int i = 0; i < 16; i++) step("fill", 1'b1, i, 1'b0, 1'b0);
      chk("full.rdy", 32'(alloc_ready), 0);
      chk("full.cnt", 32'(free_count), 0);
      step("over", 1'b1, 0, 1'b0, 1'b0);
      chk("over.t0", 32'(translation[0]), 16);
      chk("over.cnt", 32'(free_count), 0);

      if (FLUSH_ON) begin
         reset_pulse();
         step("fa1", 1'b1, 1, 1'b0, 1'b0);
         step("fa2", 1'b1, 2, 1'b0, 1'b0);
         step("fa3", 1'b1, 3, 1'b0, 1'b0);
         step("fl", 1'b0, 0, 1'b0, 1'b1);
         chk("fl.t1", 32'(translation[1]), 1);
         chk("fl.t3", 32'(translation[3]), 3);
         chk("fl.cnt", 32'(free_count), 16);
         chk("fl.preg", 32'(alloc_preg), 16);
      end

      reset_pulse();
      for (int n = 0; n < 800; n++) begin
         step("rnd",
              $urandom_range(0, 99) < 60,
              int'($urandom_range(0, 15)),
              $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rename_map.md
# rename_map

Register rename unit for the out-of-order core. It holds the speculative architectural-to-physical map and supplies the decoder with its 16-entry translation vector and the next free physical register. It also keeps a retired map updated by commit, frees superseded physical registers, and restores state on a pipeline flush.

## Interface
Parameters:
- NUM_ARCH, 16, number of architectural registers. Fixed by the ISA.
- PREG_W, $clog2(`NUM_REG), physical register index width. `NUM_REG comes from nand_cpu.svh and must be at least 17.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset. Asynchronous and active-high.
- alloc_valid  in  1  the decoder requests a destination register this cycle.
- alloc_arch  in  4  architectural destination being renamed.
- alloc_ready  out  1  at least one physical register is free.
- alloc_preg  out  PREG_W  physical register granted. This output goes to the decoder's p_reg.
- translation  out  PREG_W × 16  speculative map, unpacked [16]. This output goes to the decoder's translation.
- commit_valid  in  1  an instruction with a destination retires.
- commit_arch  in  4  its architectural destination.
- commit_preg  in  PREG_W  its physical destination.
- flush  in  1  discard all speculative renames. Present only with RENAME_FLUSH_EN.
- free_count  out  PREG_W+1  number of free physical registers.

## Operation
State:
- spec_map[16]: the speculative map.
- ret_map[16]: the retired map.
- free_mask[`NUM_REG]: one bit per physical register, set when the register is free.
- free_count: counter of set bits in free_mask.

Reset values:
- spec_map[i] = ret_map[i] = i.
- free_mask bits 16..`NUM_REG-1 are set; all others are clear.
- free_count = `NUM_REG-16.
- alloc_ready = 1.
- alloc_preg = 16.

Allocation:
- alloc_preg is the lowest-index set bit of free_mask, decoded combinationally from registered state.
- alloc_ready = |free_mask.
- When alloc_valid && alloc_ready, at the clock edge: clear free_mask[alloc_preg] and set spec_map[alloc_arch] = alloc_preg.
- When alloc_valid && !alloc_ready: no state change. The decoder stalls.

Commit:
- When commit_valid, let old = ret_map[commit_arch].
- Set ret_map[commit_arch] = commit_preg.
- Set free_mask[old]. If old == commit_preg, nothing is freed.

free_count:
- Increments on a free and decrements on an allocation.
- Is unchanged when both happen in the same cycle.
- Must always equal the popcount of free_mask.

Invariants:
- ret_map entries are pairwise distinct.
- A physical register is never both free and mapped in spec_map or ret_map.

## Timing
- Allocation has zero-cycle grant latency: alloc_preg is valid in the same cycle as alloc_valid.
- translation reflects the new mapping on the cycle after the allocation edge. Back-to-back instructions therefore see the previous instruction's rename.
- A register freed by commit becomes visible to allocation one cycle later. It is never granted in the same cycle it is freed.
- Allocation and commit in the same cycle are both applied.
- Flush takes priority over allocation. A same-cycle commit is applied first, and the flush restore uses the post-commit ret_map.
- Flush completes in one cycle. The next cycle shows:
  - spec_map = ret_map;
  - free_mask = complement of the set of registers held in ret_map;
  - free_count = `NUM_REG-16.
- An asynchronous reset mid-operation returns every register to its reset value immediately. Inputs are ignored while rst is high.

## Configuration
- RENAME_FLUSH_EN defined:
  - The flush port exists.
  - The free-mask rebuild is implemented as a 16-way decode-OR of ret_map.
- RENAME_FLUSH_EN undefined:
  - The flush port and rebuild logic are absent.
  - Recovery happens only through rst.
  - All other behaviour is identical.

## Structure
- Shared package (nand_cpu_pkg):
  - PREG_W and NUM_ARCH constants.
  - a `preg_t` typedef of PREG_W bits.
- One sub-module, `free_list`:
  - Owns free_mask, free_count and the lowest-set-bit priority encoder.
  - Inputs: alloc strobe, free strobe with index, flush with mask.
  - Outputs: alloc_preg, alloc_ready, free_count.
- rename_map itself owns spec_map and ret_map and the flush restore.

## Test plan
All scenarios use `NUM_REG=32.
- Reset, then hold idle. Required: translation[i]=i, alloc_preg=16, alloc_ready=1, free_count=16.
- alloc_valid=1, alloc_arch=0 for one cycle. Required: next cycle translation[0]=16, alloc_preg=17, free_count=15.
- 16 consecutive allocations, then a 17th. Required: alloc_ready=0 and free_count=0 after the 16th; the 17th causes no map or count change.
- commit_valid with arch 0, preg 16 after the first allocation. Required: phys 0 freed, so next cycle alloc_preg=0 and free_count increments by 1.
- Allocation and commit in the same cycle. Required: free_count unchanged; the freed register is not granted until the following cycle.
- With RENAME_FLUSH_EN: three allocations to arch 1, 2, 3, then flush. Required: next cycle translation equals ret_map (identity), free_count=16, alloc_preg=16.
